// File: rtl/alu_seq_if.sv
// Request/response bundle between the issue stage and alu_seq.
// master = requester (decode/regfile side), slave = the ALU.
interface alu_seq_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       opcode;
   logic [WIDTH-1:0] operand1;
   logic [WIDTH-1:0] operand2;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             flag_n;
   logic             flag_z;
   logic             flag_c;
   logic             flag_v;
   logic             out_err;

   modport master (
      output in_valid, opcode, operand1, operand2, out_ready,
      input  in_ready, out_valid, result, flag_n, flag_z, flag_c, flag_v, out_err
   );

   modport slave (
      input  in_valid, opcode, operand1, operand2, out_ready,
      output in_ready, out_valid, result, flag_n, flag_z, flag_c, flag_v, out_err
   );
endinterface

// File: rtl/alu_seq.sv
// Handshaked ALU with NZCV flags, bit-serial shifts and a shift-add multiplier.
// One operation in flight; results held in DONE until the consumer takes them.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | ready for a request; single-cycle ops resolve on accept
//   EXEC  | iterating a shift (one bit/cycle) or multiply (one bit/cycle)
//   DONE  | result/flags valid, held until out_ready
module alu_seq #(
   parameter int WIDTH = 32
) (
   input  logic     clk,
   input  logic     rst,
   alu_seq_if.slave bus
);
   localparam int SHW = $clog2(WIDTH);
   localparam int CW  = SHW + 1;

   localparam logic [3:0] OP_NOP = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_AND = 4'b0011;
   localparam logic [3:0] OP_OR  = 4'b0100;
   localparam logic [3:0] OP_XOR = 4'b0101;
   localparam logic [3:0] OP_NOT = 4'b0110;
   localparam logic [3:0] OP_LSL = 4'b0111;
   localparam logic [3:0] OP_LSR = 4'b1000;
   localparam logic [3:0] OP_ASR = 4'b1001;
   localparam logic [3:0] OP_MUL = 4'b1010;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic [3:0]       op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] acc_hi;
   logic [WIDTH-1:0] acc_lo;
   logic [CW-1:0]    cnt;

   logic [WIDTH-1:0] res_q;
   logic             n_q;
   logic             z_q;
   logic             c_q;
   logic             v_q;
   logic             err_q;

   logic             accept;
   logic [SHW-1:0]   shamt;
   logic             is_shift;
   logic             is_mul;
   logic             multi;
   logic             last;

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] s_res;
   logic             s_c;
   logic             s_v;
   logic             s_err;
   logic             s_flag_en;

   logic [WIDTH-1:0] sh_next;
   logic             sh_out;
   logic [WIDTH:0]   m_sum;
   logic [WIDTH-1:0] m_hi;
   logic [WIDTH-1:0] m_lo;
   logic [WIDTH-1:0] x_res;
   logic             x_c;

   assign accept   = bus.in_valid && bus.in_ready;
   assign shamt    = bus.operand2[SHW-1:0];
   assign is_shift = (bus.opcode == OP_LSL) || (bus.opcode == OP_LSR) || (bus.opcode == OP_ASR);
   assign is_mul   = (bus.opcode == OP_MUL);
   assign multi    = is_mul || (is_shift && (shamt != '0));
   assign last     = (cnt == CW'(1));

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = multi ? EXEC : DONE;
         EXEC:    if (last) state_nxt = DONE;
         DONE:    if (bus.out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      bus.in_ready  = (state == IDLE) && !rst;
      bus.out_valid = (state == DONE);
      bus.result    = res_q;
      bus.flag_n    = n_q;
      bus.flag_z    = z_q;
      bus.flag_c    = c_q;
      bus.flag_v    = v_q;
      bus.out_err   = err_q;
   end

   // Single-cycle ops evaluate straight off the request so they retire on the accept edge.
   always_comb begin
      sum       = {1'b0, bus.operand1} + {1'b0, bus.operand2};
      diff      = {1'b0, bus.operand1} - {1'b0, bus.operand2};
      s_res     = '0;
      s_c       = 1'b0;
      s_v       = 1'b0;
      s_err     = 1'b0;
      s_flag_en = 1'b1;
      case (bus.opcode)
         OP_NOP: s_flag_en = 1'b0;
         OP_ADD: begin
            s_res = sum[WIDTH-1:0];
            s_c   = sum[WIDTH];
            s_v   = (bus.operand1[WIDTH-1] == bus.operand2[WIDTH-1]) &&
                    (s_res[WIDTH-1] != bus.operand1[WIDTH-1]);
         end
         OP_SUB: begin
            s_res = diff[WIDTH-1:0];
            s_c   = diff[WIDTH];
            s_v   = (bus.operand1[WIDTH-1] != bus.operand2[WIDTH-1]) &&
                    (s_res[WIDTH-1] != bus.operand1[WIDTH-1]);
         end
         OP_AND: s_res = bus.operand1 & bus.operand2;
         OP_OR:  s_res = bus.operand1 | bus.operand2;
         OP_XOR: s_res = bus.operand1 ^ bus.operand2;
         OP_NOT: s_res = ~bus.operand1;
         OP_LSL, OP_LSR, OP_ASR: s_res = bus.operand1;
         default: begin
            s_err     = 1'b1;
            s_flag_en = 1'b0;
         end
      endcase
   end

   // One iteration step for shifts and multiply.
   always_comb begin
      sh_next = acc_lo;
      sh_out  = 1'b0;
      case (op_q)
         OP_LSL: begin
            sh_next = {acc_lo[WIDTH-2:0], 1'b0};
            sh_out  = acc_lo[WIDTH-1];
         end
         OP_LSR: begin
            sh_next = {1'b0, acc_lo[WIDTH-1:1]};
            sh_out  = acc_lo[0];
         end
         OP_ASR: begin
            sh_next = {acc_lo[WIDTH-1], acc_lo[WIDTH-1:1]};
            sh_out  = acc_lo[0];
         end
         default: ;
      endcase

      // acc_lo starts as the multiplier and fills with product bits from the top.
      m_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, a_q} : '0);
      m_hi  = m_sum[WIDTH:1];
      m_lo  = {m_sum[0], acc_lo[WIDTH-1:1]};

      x_res = (op_q == OP_MUL) ? m_lo : sh_next;
      x_c   = (op_q == OP_MUL) ? (m_hi != '0) : sh_out;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_q   <= '0;
         a_q    <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         cnt    <= '0;
         res_q  <= '0;
         n_q    <= 1'b0;
         z_q    <= 1'b0;
         c_q    <= 1'b0;
         v_q    <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  op_q <= bus.opcode;
                  if (is_mul) begin
                     a_q    <= bus.operand1;
                     acc_hi <= '0;
                     acc_lo <= bus.operand2;
                     cnt    <= CW'(WIDTH);
                  end else if (multi) begin
                     acc_lo <= bus.operand1;
                     cnt    <= {1'b0, shamt};
                  end else begin
                     res_q <= s_res;
                     n_q   <= s_res[WIDTH-1];
                     z_q   <= s_flag_en && (s_res == '0);
                     c_q   <= s_c;
                     v_q   <= s_v;
                     err_q <= s_err;
                  end
               end
            end
            EXEC: begin
               cnt <= cnt - CW'(1);
               if (op_q == OP_MUL) begin
                  acc_hi <= m_hi;
                  acc_lo <= m_lo;
               end else begin
                  acc_lo <= sh_next;
               end
               if (last) begin
                  res_q <= x_res;
                  n_q   <= x_res[WIDTH-1];
                  z_q   <= (x_res == '0);
                  c_q   <= x_c;
                  v_q   <= 1'b0;
                  err_q <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: latency, result and flag checks per opcode,
// backpressure hold, mid-operation reset and undefined opcodes.
module tb_alu_seq;
   logic clk;
   logic rst;
   int   errors;
   int   checks;

   alu_seq_if #(.WIDTH(32)) bus ();

   alu_seq #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [4:0] flags();
      return {bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v, bus.out_err};
   endfunction

   // Issue one op, scramble inputs after accept, measure edges from accept to out_valid.
   task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int exp_lat,
                         input logic [31:0] exp_res, input logic [4:0] exp_fl);
      int lat;
      lat = 0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.opcode   = op;
      bus.operand1 = a;
      bus.operand2 = b;
      do begin
         @(posedge clk);
         lat++;
         #1;
         if (lat == 1) begin
            bus.in_valid = 1'b0;
            bus.opcode   = 4'hF;
            bus.operand1 = $urandom;
            bus.operand2 = $urandom;
         end
      end while (!bus.out_valid && lat < 100);
      check({tag, " latency"}, 64'(lat), 64'(exp_lat));
      check({tag, " result"}, 64'(bus.result), 64'(exp_res));
      check({tag, " nzcv_err"}, 64'(flags()), 64'(exp_fl));
      @(posedge clk);
      #1;
      check({tag, " release"}, {62'd0, bus.out_valid, bus.in_ready}, 64'd1);
   endtask

   initial begin
      bit seen;
      errors = 0;
      checks = 0;
      rst = 1'b1;
      bus.in_valid  = 1'b0;
      bus.opcode    = 4'h0;
      bus.operand1  = '0;
      bus.operand2  = '0;
      bus.out_ready = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      check("reset out_valid", 64'(bus.out_valid), 64'd0);
      check("reset result", 64'(bus.result), 64'd0);
      check("reset flags", 64'(flags()), 64'd0);
      check("reset in_ready", 64'(bus.in_ready), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("post-reset in_ready", 64'(bus.in_ready), 64'd1);

      //                 tag        op     A             B             lat result        NZCVE
      run_op("add ovf",  4'h1, 32'h7FFFFFFF, 32'h00000001, 1,  32'h80000000, 5'b10010);
      run_op("add carry",4'h1, 32'hFFFFFFFF, 32'h00000001, 1,  32'h00000000, 5'b01100);
      run_op("sub brw",  4'h2, 32'h00000005, 32'h00000007, 1,  32'hFFFFFFFE, 5'b10100);
      run_op("sub ovf",  4'h2, 32'h80000000, 32'h00000001, 1,  32'h7FFFFFFF, 5'b00010);
      run_op("and",      4'h3, 32'hF0F0F0F0, 32'h0FF00FF0, 1,  32'h00F000F0, 5'b00000);
      run_op("or",       4'h4, 32'hF0F0F0F0, 32'h0FF00FF0, 1,  32'hFFF0FFF0, 5'b10000);
      run_op("xor",      4'h5, 32'hF0F0F0F0, 32'h0FF00FF0, 1,  32'hFF00FF00, 5'b10000);
      run_op("not",      4'h6, 32'hFFFFFFFF, 32'h12345678, 1,  32'h00000000, 5'b01000);
      run_op("lsl 31",   4'h7, 32'h00000001, 32'h0000001F, 32, 32'h80000000, 5'b10000);
      run_op("lsl 0",    4'h7, 32'h12345678, 32'h00000020, 1,  32'h12345678, 5'b00000);
      run_op("lsr 1",    4'h8, 32'h00000003, 32'h00000001, 2,  32'h00000001, 5'b00100);
      run_op("asr 4",    4'h9, 32'h80000000, 32'h00000004, 5,  32'hF8000000, 5'b10000);
      run_op("mul hi",   4'hA, 32'h00010000, 32'h00010000, 33, 32'h00000000, 5'b01100);
      run_op("mul 3x5",  4'hA, 32'h00000003, 32'h00000005, 33, 32'h0000000F, 5'b00000);
      run_op("nop",      4'h0, 32'h00000004, 32'h00000004, 1,  32'h00000000, 5'b00000);
      run_op("undef b",  4'hB, 32'h00000004, 32'h00000004, 1,  32'h00000000, 5'b00001);

      // Backpressure: result must hold while a competing request is ignored.
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.opcode    = 4'h1;
      bus.operand1  = 32'd2;
      bus.operand2  = 32'd3;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      check("bp first valid", 64'(bus.out_valid), 64'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.opcode   = 4'h2;
         bus.operand1 = 32'd9;
         bus.operand2 = 32'd1;
         @(posedge clk);
         #1;
         check("bp hold", {bus.out_valid, bus.in_ready, bus.result, 5'(flags()), 25'd0},
               {1'b1, 1'b0, 32'd5, 5'b00000, 25'd0});
      end
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp release", {62'd0, bus.out_valid, bus.in_ready}, 64'd1);
      seen = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) seen = 1'b1;
      end
      check("bp no queued op", 64'(seen), 64'd0);

      // Reset ten cycles into a multiply.
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.opcode   = 4'hA;
      bus.operand1 = 32'd7;
      bus.operand2 = 32'd9;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rst mid mul", {bus.out_valid, bus.in_ready, bus.result, 5'(flags()), 25'd0}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst release in_ready", 64'(bus.in_ready), 64'd1);
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) seen = 1'b1;
      end
      check("rst abandoned op", 64'(seen), 64'd0);

      run_op("undef f",  4'hF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1,  32'h00000000, 5'b00001);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
